load_return_stage: RTL and testbench

- Sits between the load/store issue logic and the writeback stage.
- Queues one load_attributes_t per issued load. Accepts in-order data returns from the selected data sub-unit, then aligns and sign-extends or NaN-boxes the data.
- Emits a registered wb_packet_t for integer loads or a registered fp_wb_packet_t for FP loads.
- Also reassembles double-precision loads that the LSU issues as two 32-bit accesses.

---
 rtl/load_return_stage_pkg.sv | 55 +++++
 rtl/load_return_stage_if.sv | 17 +
 rtl/load_return_stage_attr_fifo.sv | 54 +++++
 rtl/load_return_stage.sv | 166 ++++++++++++++++
 tb/tb_load_return_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_return_stage_pkg.sv
// Shared types for the load return path: load attributes, writeback packets,
// FP load sequencing ops and the integer alignment selector.
package load_return_stage_pkg;

  localparam int NUM_SUB_UNITS     = 3;
  localparam int NUM_SUB_UNITS_W   = 2;
  localparam int XLEN              = 32;
  localparam int FLEN              = 64;
  localparam int LOAD_ID_W         = 4;
  localparam int LOAD_RETURN_DEPTH = 4;

  // How a returned word is finished off.
  typedef enum logic [1:0] {
    INT_DONE    = 2'd0,
    SINGLE_DONE = 2'd1,
    DOUBLE_HOLD = 2'd2,
    DOUBLE_DONE = 2'd3
  } fp_ls_op_t;

  // Integer result width selector; encoding 3 also means a full word.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } load_align_sel_t;

  typedef struct packed {
    logic [LOAD_ID_W-1:0]       id;
    logic [NUM_SUB_UNITS_W-1:0] subunit_id;
    fp_ls_op_t                  fp_op;
    logic [1:0]                 byte_addr;
    logic [1:0]                 final_mux_sel;
    logic [1:0]                 sign_sel;
    logic                       is_signed;
  } load_attributes_t;

  typedef struct packed {
    logic                 valid;
    logic [LOAD_ID_W-1:0] id;
    logic [XLEN-1:0]      data;
  } wb_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [LOAD_ID_W-1:0] id;
    logic [FLEN-1:0]      data;
  } fp_wb_packet_t;

  // Single-precision values live in the low half of an FLEN register,
  // with the upper bits forced to all ones.
  function automatic logic [FLEN-1:0] nan_box(input logic [31:0] word);
    return {{(FLEN-32){1'b1}}, word};
  endfunction

endpackage

// File: rtl/load_return_stage_if.sv
// Data-return bus from the LSU data sub-units: per-lane valid and data, one
// shared acknowledge for the return currently being consumed.
interface load_return_stage_if
  import load_return_stage_pkg::*;
#(
  parameter int SUBUNITS = NUM_SUB_UNITS
) ();

  logic [SUBUNITS-1:0]    sub_valid;
  logic [SUBUNITS*32-1:0] sub_data;
  logic                   sub_ack;

  // Sub-unit side drives returns, the load return stage acknowledges.
  modport master (output sub_valid, output sub_data, input sub_ack);
  modport slave  (input sub_valid, input sub_data, output sub_ack);

endinterface

// File: rtl/load_return_stage_attr_fifo.sv
// Generic synchronous FIFO holding the attributes of outstanding loads.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module load_attr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full is judged before any same-cycle pop, so a push at full is dropped.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Read/write pointers; natural wrap through the extra MSB.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; entries are only read once the pointers
  // say they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/load_return_stage.sv
// Load return stage: pairs in-order sub-unit data returns with queued load
// attributes, aligns/sign-extends integer loads, NaN-boxes single loads and
// stitches double loads from two 32-bit halves into registered writebacks.
module load_return_stage
  import load_return_stage_pkg::*;
#(
  parameter int DEPTH    = LOAD_RETURN_DEPTH,
  parameter int SUBUNITS = NUM_SUB_UNITS,
  parameter bit FP_EN    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       attr_push,
  input  load_attributes_t           attr_in,
  output logic                       attr_full,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       idle,
  load_return_stage_if.slave         ret,
  output wb_packet_t                 wb_out,
  input  logic                       wb_ack,
  output fp_wb_packet_t              fp_wb_out,
  input  logic                       fp_wb_ack,
  output logic                       order_error
);

  localparam int AW = $clog2(DEPTH + 1);

  load_attributes_t                      head;
  logic [$bits(load_attributes_t)-1:0]   head_bits;
  logic                                  empty;
  logic                                  head_valid;
  logic                                  stray_valid;
  logic                                  slot_free;
  logic                                  ack_int;
  logic                                  ack_done;
  logic [31:0]                           lane;
  logic [31:0]                           shifted;
  logic [31:0]                           aligned;
  logic                                  sign_bit;
  wb_packet_t                            wb_q;
  fp_wb_packet_t                         fp_q;
  logic                                  hold_valid;

  load_attr_fifo #(
    .WIDTH ($bits(load_attributes_t)),
    .DEPTH (DEPTH)
  ) u_attr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (attr_push),
    .din   (attr_in),
    .pop   (ret.sub_ack),
    .dout  (head_bits),
    .full  (attr_full),
    .empty (empty),
    .count (outstanding)
  );

  assign head = load_attributes_t'(head_bits);

  // Pick the head load's lane; a valid on any other lane is out of order.
  // NOTE: every output of a combinational block gets a default up front so
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    head_valid  = 1'b0;
    stray_valid = 1'b0;
    lane        = '0;
    for (int i = 0; i < SUBUNITS; i++) begin
      if (!empty && head.subunit_id == NUM_SUB_UNITS_W'(i)) begin
        head_valid = ret.sub_valid[i];
        lane       = ret.sub_data[32*i +: 32];
      end else if (ret.sub_valid[i]) begin
        stray_valid = 1'b1;
      end
    end
  end

  // The destination register must be empty or draining this cycle.
  always_comb begin
    slot_free = 1'b1;
    case (head.fp_op)
      INT_DONE:                 slot_free = ~wb_q.valid | wb_ack;
      SINGLE_DONE, DOUBLE_DONE: slot_free = ~fp_q.valid | fp_wb_ack;
      default:                  slot_free = 1'b1;
    endcase
  end

  assign ret.sub_ack = head_valid & slot_free;
  assign ack_int     = ret.sub_ack & (head.fp_op == INT_DONE);
  assign ack_done    = ret.sub_ack & (head.fp_op == DOUBLE_DONE);

  // Shift the addressed bytes down and extend from the selected sign byte.
  always_comb begin
    shifted  = lane >> {head.byte_addr, 3'b000};
    sign_bit = 1'b0;
    aligned  = shifted;
    case (head.final_mux_sel)
      BYTE: begin
        sign_bit = head.is_signed & lane[{head.sign_sel, 3'b111}];
        aligned  = {{24{sign_bit}}, shifted[7:0]};
      end
      HALF: begin
        sign_bit = head.is_signed & lane[{head.sign_sel[1], 1'b1, 3'b111}];
        aligned  = {{16{sign_bit}}, shifted[15:0]};
      end
      default: aligned = shifted;
    endcase
  end

  // Integer writeback register: load on accept, otherwise drop on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (ack_int) begin
      wb_q <= '{valid: 1'b1, id: head.id, data: aligned};
    end else if (wb_ack) begin
      wb_q.valid <= 1'b0;
    end
  end

  generate
    if (FP_EN) begin : g_fp
      logic [31:0] hold_lo;

      // FP writeback register and low-half hold for split double loads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fp_q       <= '0;
          hold_lo    <= '0;
          hold_valid <= 1'b0;
        end else begin
          if (ret.sub_ack && head.fp_op == SINGLE_DONE) begin
            fp_q <= '{valid: 1'b1, id: head.id, data: nan_box(lane)};
          end else if (ack_done) begin
            fp_q <= '{valid: 1'b1, id: head.id, data: {lane, hold_lo}};
          end else if (fp_wb_ack) begin
            fp_q.valid <= 1'b0;
          end
          if (ret.sub_ack && head.fp_op == DOUBLE_HOLD) begin
            hold_lo    <= lane;
            hold_valid <= 1'b1;
          end else if (ack_done) begin
            hold_valid <= 1'b0;
          end
        end
      end
    end else begin : g_no_fp
      assign fp_q       = '0;
      assign hold_valid = 1'b0;
    end
  endgenerate

  // Sticky flag for returns that break in-order pairing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_error <= 1'b0;
    end else if (stray_valid || (ack_done && !hold_valid)) begin
      order_error <= 1'b1;
    end
  end

  assign wb_out    = wb_q;
  assign fp_wb_out = fp_q;
  assign idle      = empty & ~wb_q.valid & ~fp_q.valid & ~hold_valid;

endmodule

// File: tb/tb_load_return_stage.sv
// Directed bench for load_return_stage: integer alignment, backpressure,
// split double loads, FIFO full/wrap, order errors and async reset.
module tb_load_return_stage;
  import load_return_stage_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             attr_push;
  load_attributes_t attr_in;
  logic             attr_full;
  logic [2:0]       outstanding;
  logic             idle;
  wb_packet_t       wb_out;
  logic             wb_ack;
  fp_wb_packet_t    fp_wb_out;
  logic             fp_wb_ack;
  logic             order_error;

  int compared   = 0;
  int mismatched = 0;

  load_return_stage_if #(.SUBUNITS(NUM_SUB_UNITS)) ret_if ();

  load_return_stage #(
    .DEPTH    (4),
    .SUBUNITS (NUM_SUB_UNITS),
    .FP_EN    (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .attr_push   (attr_push),
    .attr_in     (attr_in),
    .attr_full   (attr_full),
    .outstanding (outstanding),
    .idle        (idle),
    .ret         (ret_if.slave),
    .wb_out      (wb_out),
    .wb_ack      (wb_ack),
    .fp_wb_out   (fp_wb_out),
    .fp_wb_ack   (fp_wb_ack),
    .order_error (order_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic load_attributes_t mk(input logic [3:0] id, input logic [1:0] sub,
                                          input fp_ls_op_t op, input logic [1:0] ba,
                                          input logic [1:0] mux, input logic [1:0] ss,
                                          input logic sg);
    load_attributes_t a;
    a.id = id; a.subunit_id = sub; a.fp_op = op; a.byte_addr = ba;
    a.final_mux_sel = mux; a.sign_sel = ss; a.is_signed = sg;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_attr(input load_attributes_t a);
    attr_push = 1'b1;
    attr_in   = a;
    tick();
    attr_push = 1'b0;
  endtask

  // Present one return and hold it until acknowledged (bounded wait).
  task automatic return_word(input int sub, input logic [31:0] data);
    logic got;
    got = 1'b0;
    ret_if.sub_valid[sub]         = 1'b1;
    ret_if.sub_data[32*sub +: 32] = data;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ret_if.sub_ack) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("ack_wait", got, 1);
    tick();
    ret_if.sub_valid[sub] = 1'b0;
  endtask

  // One integer load through sub-unit 0 with full latency checking.
  task automatic do_int(input string tag, input logic [3:0] id, input logic [1:0] ba,
                        input logic [1:0] mux, input logic [1:0] ss, input logic sg,
                        input logic [31:0] data, input logic [31:0] exp);
    push_attr(mk(id, 2'd0, INT_DONE, ba, mux, ss, sg));
    check({tag, "_occ"}, outstanding, 1);
    ret_if.sub_valid[0]    = 1'b1;
    ret_if.sub_data[31:0]  = data;
    #1;
    check({tag, "_ack"}, ret_if.sub_ack, 1);
    check({tag, "_lat"}, wb_out.valid, 0);
    tick();
    ret_if.sub_valid[0] = 1'b0;
    check({tag, "_valid"}, wb_out.valid, 1);
    check({tag, "_data"}, wb_out.data, exp);
    check({tag, "_id"}, wb_out.id, id);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check({tag, "_clear"}, wb_out.valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] q[$];
    logic [3:0] nid;
    logic [3:0] exp_id;

    rst_n = 1'b0; attr_push = 1'b0; attr_in = '0;
    wb_ack = 1'b0; fp_wb_ack = 1'b0;
    ret_if.sub_valid = '0; ret_if.sub_data = '0;
    #22;
    check("rst_occ", outstanding, 0);
    check("rst_idle", idle, 1);
    check("rst_wb", wb_out.valid, 0);
    check("rst_fp", fp_wb_out.valid, 0);
    check("rst_err", order_error, 0);
    check("rst_ack", ret_if.sub_ack, 0);
    check("rst_full", attr_full, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Integer alignment vectors
    do_int("lbu", 4'd1, 2'd3, 2'd0, 2'd3, 1'b0, 32'h80FF_1234, 32'h0000_0080);
    do_int("lb",  4'd2, 2'd3, 2'd0, 2'd3, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80);
    do_int("lh",  4'd3, 2'd2, 2'd1, 2'd2, 1'b1, 32'h8001_0000, 32'hFFFF_8001);
    do_int("lw",  4'd4, 2'd0, 2'd2, 2'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_int("lbp", 4'd5, 2'd1, 2'd0, 2'd1, 1'b1, 32'h0000_7F00, 32'h0000_007F);

    // Backpressure on the integer writeback register
    push_attr(mk(4'd5, 2'd0, INT_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    push_attr(mk(4'd6, 2'd1, INT_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    check("bp_occ2", outstanding, 2);
    ret_if.sub_valid[0] = 1'b1; ret_if.sub_data[31:0] = 32'hAAAA_0005;
    #1; check("bp_ack1", ret_if.sub_ack, 1);
    tick(); ret_if.sub_valid[0] = 1'b0;
    check("bp_data1", wb_out.data, 32'hAAAA_0005);
    check("bp_id1", wb_out.id, 5);
    check("bp_occ1", outstanding, 1);
    ret_if.sub_valid[1] = 1'b1; ret_if.sub_data[63:32] = 32'hBBBB_0006;
    #1; check("bp_stall", ret_if.sub_ack, 0);
    tick();
    #1; check("bp_stall2", ret_if.sub_ack, 0);
    check("bp_hold", wb_out.data, 32'hAAAA_0005);
    check("bp_occ_hold", outstanding, 1);
    wb_ack = 1'b1;
    #1; check("bp_release", ret_if.sub_ack, 1);
    tick(); ret_if.sub_valid[1] = 1'b0;
    check("bp_b2b_valid", wb_out.valid, 1);
    check("bp_data2", wb_out.data, 32'hBBBB_0006);
    check("bp_id2", wb_out.id, 6);
    check("bp_occ0", outstanding, 0);
    tick(); wb_ack = 1'b0;
    check("bp_clear", wb_out.valid, 0);

    // Split double and NaN-boxed single
    push_attr(mk(4'd7, 2'd2, DOUBLE_HOLD, 2'd0, 2'd2, 2'd0, 1'b0));
    push_attr(mk(4'd7, 2'd2, DOUBLE_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    return_word(2, 32'h1111_2222);
    check("dbl_nofp", fp_wb_out.valid, 0);
    check("dbl_notidle", idle, 0);
    check("dbl_occ1", outstanding, 1);
    return_word(2, 32'h3333_4444);
    check("dbl_valid", fp_wb_out.valid, 1);
    check("dbl_data", fp_wb_out.data, 64'h3333_4444_1111_2222);
    check("dbl_id", fp_wb_out.id, 7);
    check("dbl_err", order_error, 0);
    fp_wb_ack = 1'b1; tick(); fp_wb_ack = 1'b0;
    check("dbl_clear", fp_wb_out.valid, 0);
    push_attr(mk(4'd8, 2'd1, SINGLE_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    return_word(1, 32'h3F80_0000);
    check("sgl_data", fp_wb_out.data, 64'hFFFF_FFFF_3F80_0000);
    check("sgl_id", fp_wb_out.id, 8);
    fp_wb_ack = 1'b1; tick(); fp_wb_ack = 1'b0;
    check("sgl_idle", idle, 1);

    // Fill to capacity, refuse the extra push, then stream with wrap
    for (int k = 0; k < 5; k++) begin
      push_attr(mk(4'(9 + k), 2'd0, INT_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
      if (k == 3) begin
        check("full_flag", attr_full, 1);
        check("full_occ", outstanding, 4);
      end
    end
    check("full_refused", outstanding, 4);
    q = '{4'd9, 4'd10, 4'd11, 4'd12};
    nid = 4'd14;
    wb_ack = 1'b1;
    ret_if.sub_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      ret_if.sub_data[31:0] = 32'hD000_0000 | 32'(q[0]);
      attr_push = 1'b1;
      attr_in   = mk(nid, 2'd0, INT_DONE, 2'd0, 2'd2, 2'd0, 1'b0);
      #1;
      check("wrap_full", attr_full, (cyc == 0) ? 1 : 0);
      check("wrap_ack", ret_if.sub_ack, 1);
      exp_id = q.pop_front();
      if (cyc != 0) begin
        q.push_back(nid);
        nid = nid + 4'd1;
      end
      tick();
      check("wrap_data", wb_out.data, 32'hD000_0000 | 32'(exp_id));
      check("wrap_id", wb_out.id, exp_id);
      check("wrap_occ", outstanding, 3);
    end
    attr_push = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ret_if.sub_data[31:0] = 32'hD000_0000 | 32'(q[0]);
      #1;
      check("drain_ack", ret_if.sub_ack, 1);
      exp_id = q.pop_front();
      tick();
      check("drain_id", wb_out.id, exp_id);
      check("drain_occ", outstanding, 2 - d);
    end
    ret_if.sub_valid[0] = 1'b0;
    tick();
    wb_ack = 1'b0;
    check("drain_clear", wb_out.valid, 0);
    check("drain_idle", idle, 1);

    // Return from the wrong sub-unit
    check("pre_err", order_error, 0);
    push_attr(mk(4'd1, 2'd0, INT_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    ret_if.sub_valid[1] = 1'b1; ret_if.sub_data[63:32] = 32'h0BAD_0BAD;
    #1; check("ord_noack", ret_if.sub_ack, 0);
    tick(); ret_if.sub_valid[1] = 1'b0;
    check("ord_err", order_error, 1);
    check("ord_occ", outstanding, 1);
    tick();
    check("ord_sticky", order_error, 1);
    return_word(0, 32'h5555_AAAA);
    check("ord_data", wb_out.data, 32'h5555_AAAA);
    wb_ack = 1'b1; tick(); wb_ack = 1'b0;

    // Async reset in the middle of a split double
    push_attr(mk(4'd2, 2'd2, DOUBLE_HOLD, 2'd0, 2'd2, 2'd0, 1'b0));
    push_attr(mk(4'd2, 2'd2, DOUBLE_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    return_word(2, 32'hCAFE_0001);
    check("mid_notidle", idle, 0);
    #2; rst_n = 1'b0;
    #1;
    check("arst_idle", idle, 1);
    check("arst_occ", outstanding, 0);
    check("arst_err", order_error, 0);
    check("arst_wb", wb_out.valid, 0);
    check("arst_fp", fp_wb_out.valid, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // A lone DOUBLE_DONE now finds no held half
    push_attr(mk(4'd3, 2'd2, DOUBLE_DONE, 2'd0, 2'd2, 2'd0, 1'b0));
    return_word(2, 32'h7777_8888);
    check("nohold_valid", fp_wb_out.valid, 1);
    check("nohold_data", fp_wb_out.data, 64'h7777_8888_0000_0000);
    check("nohold_err", order_error, 1);
    fp_wb_ack = 1'b1; tick(); fp_wb_ack = 1'b0;
    check("final_idle", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
